seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side decoder for the multiplexed four-digit seven-segment bus driven by the display driver. It samples the active-low anode and segment lines and rebuilds the four displayed BCD digits, emitting a one-cycle `frame_valid` each time all four digits have been captured. It also flags malformed patterns and a stalled scan. It sits beside the display driver as a self-check and loopback monitor, and the testbench uses it as the reference decoder for displayed time and score.

## Interface
- SETTLE_CYCLES, 2: consecutive cycles the `{anode, segment}` pair must be unchanged before a digit is captured; minimum 1.
- TIMEOUT_CYCLES, 1024: cycles without any change on the anode lines before `stalled` asserts.
- clk_fast  in  1  sampling clock; the same clock that advances the driver's digit counter.
- rst_n  in  1  asynchronous, active-low reset.
- Anode_Activate  in  4  active-low digit enables; 0111 = digit 3 (leftmost) … 1110 = digit 0.
- LED_out  in  7  active-low segments; bit6 = a … bit0 = g.
- err_clr  in  1  synchronous clear of the sticky error flags.
- digits  out  16  captured BCD; [15:12] = digit 3. Code 4'hA = blank, 4'hF = unrecognised pattern.
- frame_valid  out  1  one-cycle pulse when `digits` updates.
- seg_err  out  4  sticky; one bit per digit index, set when that digit decoded to 4'hF.
- anode_err  out  1  sticky; set when the anode lines carried a pattern that is neither one-hot-low nor 1111.
- stalled  out  1  level; high while the anode lines have been unchanged for ≥ TIMEOUT_CYCLES.
- minutes  out  7  binary value of digit3·10 + digit2.
- seconds  out  7  binary value of digit1·10 + digit0.

## Operation
- The inputs are registered once into sample registers. Every later decision uses the sample registers and the previous sample.
- **stable_cnt** (saturating):
  - Cleared when the sample differs from the previous sample; otherwise increments.
- **Capture:**
  - Occurs once per stable window, in the cycle stable_cnt reaches SETTLE_CYCLES−1.
  - Requires the anode sample to be one-hot-low.
  - The decoded code is written to the pending slot for that digit, and the digit's bit is set in `cap_mask`.
- **Pattern decode:**
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1111111→A (blank).
  - Any other pattern → F, and the matching `seg_err` bit is set.
- **Anode 1111** (all digits off): ignored; no capture and no error.
- **Invalid anode** (more than one low bit): sets `anode_err`; no capture.
- **Frame complete:**
  - When `cap_mask` becomes 1111, all four pending slots are copied to `digits` on the next edge, `frame_valid` pulses, and `cap_mask` clears on that same edge.
  - A re-capture of an already-captured digit before the frame completes overwrites its pending slot.
- **Binary outputs:**
  - Updated alongside `digits` when no digit in the frame is F; a blank digit counts as 0.
  - If any digit in the frame is F, the binary outputs hold their previous value.
  - Maximum value is 99, so 7 bits are sufficient.
- **Stall counter:**
  - Cleared on any change of the anode sample; increments and saturates at TIMEOUT_CYCLES.
  - `stalled` = (counter == TIMEOUT_CYCLES).
- **err_clr and a new error in the same cycle:** the error wins and its bit stays set.

## Timing
- Reset values:
  - All outputs are 0, including `digits` = 16'h0000 and `stalled` = 0.
  - `cap_mask` and `stable_cnt` are cleared.
- Reset mid-frame discards all pending captures; the next frame needs four fresh captures.
- Capture latency: with SETTLE_CYCLES = N, a digit whose pins change at edge k is captured at edge k+1+N−1+1 (one input register plus the settle count).
- `frame_valid` occurs one cycle after the capture that completes the mask.
- A window shorter than SETTLE_CYCLES is never captured, including a single-cycle glitch.
- Outputs are registered with no combinational input→output path.

## Configuration
- **SEG7_DECODE_BIN_EN defined:** `minutes` and `seconds` are computed as described in Operation.
- **SEG7_DECODE_BIN_EN undefined:** the conversion logic is omitted; `minutes` and `seconds` are tied to 0 while the ports remain present.

## Structure
- Shared package **seg7_pkg** holds:
  - the ten digit segment patterns and the blank pattern;
  - the code constants SEG7_BLANK = 4'hA and SEG7_BAD = 4'hF;
  - the four anode one-hot-low constants.
  - The display driver also uses this package.
- One sub-module: **seg7_pattern_decode**, a combinational 7-bit pattern to 4-bit code decoder with a `bad` flag. It is instantiated once on the sample register.

## Test plan
- **Valid scan:** SETTLE_CYCLES = 2; scan "12:34", each digit held 4 cycles → one `frame_valid`, `digits` = 16'h1234, `minutes` = 12, `seconds` = 34, no errors.
- **Glitch rejection:** digit 2 held for only 1 cycle inside a scan → no capture of digit 2; `frame_valid` appears only after a later valid 4-cycle hold of digit 2.
- **Bad pattern:** LED_out = 1111110 on digit 0 → `digits[3:0]` = F, `seg_err` = 0001, `minutes` and `seconds` unchanged.
- **Invalid anode:** Anode_Activate = 0011 for 5 cycles → `anode_err` = 1, no capture. Then `err_clr` for 1 cycle → `anode_err` = 0 on the next edge.
- **Stall and reset:**
  - Freeze the anode lines for 1024 cycles → `stalled` = 1; one anode change → `stalled` = 0 two edges later.
  - Assert `rst_n` low after 2 captures → all outputs 0; the next frame needs four fresh captures.
- **Macro off:** with SEG7_DECODE_BIN_EN undefined, repeat the "12:34" scan → `digits` = 16'h1234, `minutes` = `seconds` = 0.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared seven-segment constants (patterns, codes, anode enables)
//               used by the display driver and the scan decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-low segment patterns, bit6 = a ... bit0 = g
    localparam logic [6:0] SEG7_PAT_0     = 7'b0000001;
    localparam logic [6:0] SEG7_PAT_1     = 7'b1001111;
    localparam logic [6:0] SEG7_PAT_2     = 7'b0010010;
    localparam logic [6:0] SEG7_PAT_3     = 7'b0000110;
    localparam logic [6:0] SEG7_PAT_4     = 7'b1001100;
    localparam logic [6:0] SEG7_PAT_5     = 7'b0100100;
    localparam logic [6:0] SEG7_PAT_6     = 7'b0100000;
    localparam logic [6:0] SEG7_PAT_7     = 7'b0001111;
    localparam logic [6:0] SEG7_PAT_8     = 7'b0000000;
    localparam logic [6:0] SEG7_PAT_9     = 7'b0000100;
    localparam logic [6:0] SEG7_PAT_BLANK = 7'b1111111;

    localparam logic [9:0][6:0] SEG7_DIGIT_PATS = {
        SEG7_PAT_9, SEG7_PAT_8, SEG7_PAT_7, SEG7_PAT_6, SEG7_PAT_5,
        SEG7_PAT_4, SEG7_PAT_3, SEG7_PAT_2, SEG7_PAT_1, SEG7_PAT_0
    };

    localparam logic [3:0] SEG7_BLANK = 4'hA;
    localparam logic [3:0] SEG7_BAD   = 4'hF;

    localparam logic [3:0] SEG7_AN_D0  = 4'b1110;
    localparam logic [3:0] SEG7_AN_D1  = 4'b1101;
    localparam logic [3:0] SEG7_AN_D2  = 4'b1011;
    localparam logic [3:0] SEG7_AN_D3  = 4'b0111;
    localparam logic [3:0] SEG7_AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        SEG7_AN_KIND_IDLE    = 2'd0,
        SEG7_AN_KIND_DIGIT   = 2'd1,
        SEG7_AN_KIND_INVALID = 2'd2
    } seg7_anode_kind_e;

    // Blank and unrecognised digits contribute zero to the binary value
    function automatic logic [3:0] seg7_code_to_bin(input logic [3:0] code);
        return (code <= 4'd9) ? code : 4'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_decoder_if
// Description : Display bus (anode/segment lines) plus decoded results and
//               status of the scan decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_decoder_if;
    logic [3:0]  Anode_Activate;
    logic [6:0]  LED_out;
    logic        err_clr;
    logic [15:0] digits;
    logic        frame_valid;
    logic [3:0]  seg_err;
    logic        anode_err;
    logic        stalled;
    logic [6:0]  minutes;
    logic [6:0]  seconds;

    modport master (
        output Anode_Activate, LED_out, err_clr,
        input  digits, frame_valid, seg_err, anode_err, stalled, minutes, seconds
    );

    modport slave (
        input  Anode_Activate, LED_out, err_clr,
        output digits, frame_valid, seg_err, anode_err, stalled, minutes, seconds
    );
endinterface
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pattern_decode
// Description : Combinational active-low 7-segment pattern to BCD code decoder;
//               blank maps to SEG7_BLANK, anything unknown to SEG7_BAD.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_code,
    output logic       o_bad
);

    always_comb begin
        o_code = SEG7_BAD;
        o_bad  = 1'b1;
        if (i_pattern == SEG7_PAT_BLANK) begin
            o_code = SEG7_BLANK;
            o_bad  = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            if (i_pattern == SEG7_DIGIT_PATS[i]) begin
                o_code = 4'(i);
                o_bad  = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_decoder
// Description : Rebuilds four BCD digits from a multiplexed active-low
//               seven-segment bus, flags bad patterns/anodes and scan stalls.
//               Macro SEG7_DECODE_BIN_EN enables the minutes/seconds outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
)
(
    input  logic                clk_fast,
    input  logic                rst_n,
    seg7_scan_decoder_if.slave  bus
);

    localparam int c_SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);
    localparam logic [c_SW-1:0] c_SETTLE_SAT  = c_SW'(SETTLE_CYCLES);
    localparam logic [c_TW-1:0] c_TIMEOUT     = c_TW'(TIMEOUT_CYCLES);

    logic [3:0]       r_anode_s, r_anode_p;
    logic [6:0]       r_seg_s, r_seg_p;
    logic [c_SW-1:0]  r_stable_cnt;
    logic [c_TW-1:0]  r_stall_cnt;
    logic [3:0][3:0]  r_pending;
    logic [3:0]       r_cap_mask;
    logic [15:0]      r_digits;
    logic             r_frame_valid;
    logic [3:0]       r_seg_err;
    logic             r_anode_err;
    logic             r_stalled;

    logic [c_SW-1:0]  w_stable_next;
    logic [c_TW-1:0]  w_stall_next;
    logic             w_changed;
    logic             w_an_changed;
    seg7_anode_kind_e w_kind;
    logic [1:0]       w_idx;
    logic [3:0]       w_code;
    logic             w_bad;
    logic             w_capture;
    logic [3:0]       w_cap_bit;
    logic             w_frame_done;

    seg7_pattern_decode u_decode (
        .i_pattern (r_seg_s),
        .o_code    (w_code),
        .o_bad     (w_bad)
    );

    assign w_changed    = {r_anode_s, r_seg_s} != {r_anode_p, r_seg_p};
    assign w_an_changed = r_anode_s != r_anode_p;

    // Saturating at SETTLE_CYCLES makes "next == SETTLE_CYCLES-1" true exactly once per window
    always_comb begin
        w_stable_next = r_stable_cnt;
        if (w_changed) begin
            w_stable_next = '0;
        end else if (r_stable_cnt != c_SETTLE_SAT) begin
            w_stable_next = r_stable_cnt + 1'b1;
        end
    end

    always_comb begin
        w_stall_next = r_stall_cnt;
        if (w_an_changed) begin
            w_stall_next = '0;
        end else if (r_stall_cnt != c_TIMEOUT) begin
            w_stall_next = r_stall_cnt + 1'b1;
        end
    end

    always_comb begin
        w_kind = SEG7_AN_KIND_INVALID;
        w_idx  = 2'd0;
        case (r_anode_s)
            SEG7_AN_D0:  begin w_kind = SEG7_AN_KIND_DIGIT; w_idx = 2'd0; end
            SEG7_AN_D1:  begin w_kind = SEG7_AN_KIND_DIGIT; w_idx = 2'd1; end
            SEG7_AN_D2:  begin w_kind = SEG7_AN_KIND_DIGIT; w_idx = 2'd2; end
            SEG7_AN_D3:  begin w_kind = SEG7_AN_KIND_DIGIT; w_idx = 2'd3; end
            SEG7_AN_OFF: w_kind = SEG7_AN_KIND_IDLE;
            default:     w_kind = SEG7_AN_KIND_INVALID;
        endcase
    end

    assign w_capture    = (w_stable_next == c_SETTLE_LAST) && (w_kind == SEG7_AN_KIND_DIGIT);
    assign w_cap_bit    = w_capture ? (4'b0001 << w_idx) : 4'b0000;
    assign w_frame_done = (r_cap_mask == 4'hF);

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            r_anode_s     <= SEG7_AN_OFF;
            r_seg_s       <= SEG7_PAT_BLANK;
            r_anode_p     <= SEG7_AN_OFF;
            r_seg_p       <= SEG7_PAT_BLANK;
            r_stable_cnt  <= '0;
            r_stall_cnt   <= '0;
            r_pending     <= '0;
            r_cap_mask    <= 4'h0;
            r_digits      <= 16'h0000;
            r_frame_valid <= 1'b0;
            r_seg_err     <= 4'h0;
            r_anode_err   <= 1'b0;
            r_stalled     <= 1'b0;
        end else begin
            r_anode_s    <= bus.Anode_Activate;
            r_seg_s      <= bus.LED_out;
            r_anode_p    <= r_anode_s;
            r_seg_p      <= r_seg_s;
            r_stable_cnt <= w_stable_next;
            r_stall_cnt  <= w_stall_next;
            r_stalled    <= (w_stall_next == c_TIMEOUT);

            for (int i = 0; i < 4; i++) begin
                if (w_cap_bit[i]) begin
                    r_pending[i] <= w_code;
                end
            end

            // A capture on the completing edge already belongs to the next frame
            r_cap_mask    <= (w_frame_done ? 4'h0 : r_cap_mask) | w_cap_bit;
            r_frame_valid <= w_frame_done;
            if (w_frame_done) begin
                r_digits <= {r_pending[3], r_pending[2], r_pending[1], r_pending[0]};
            end

            // Set terms are OR-ed after the clear so a coincident error survives err_clr
            r_seg_err   <= (bus.err_clr ? 4'h0 : r_seg_err) | (w_bad ? w_cap_bit : 4'h0);
            r_anode_err <= (bus.err_clr ? 1'b0 : r_anode_err) | (w_kind == SEG7_AN_KIND_INVALID);
        end
    end

`ifdef SEG7_DECODE_BIN_EN
    logic [6:0] r_minutes, r_seconds;
    logic [6:0] w_min_next, w_sec_next;
    logic       w_frame_has_bad;

    always_comb begin
        w_frame_has_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_pending[i] == SEG7_BAD) begin
                w_frame_has_bad = 1'b1;
            end
        end
    end

    assign w_min_next = 7'(seg7_code_to_bin(r_pending[3])) * 7'd10 + 7'(seg7_code_to_bin(r_pending[2]));
    assign w_sec_next = 7'(seg7_code_to_bin(r_pending[1])) * 7'd10 + 7'(seg7_code_to_bin(r_pending[0]));

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            r_minutes <= 7'd0;
            r_seconds <= 7'd0;
        end else if (w_frame_done && !w_frame_has_bad) begin
            r_minutes <= w_min_next;
            r_seconds <= w_sec_next;
        end
    end

    assign bus.minutes = r_minutes;
    assign bus.seconds = r_seconds;
`else
    assign bus.minutes = 7'd0;
    assign bus.seconds = 7'd0;
`endif

    assign bus.digits      = r_digits;
    assign bus.frame_valid = r_frame_valid;
    assign bus.seg_err     = r_seg_err;
    assign bus.anode_err   = r_anode_err;
    assign bus.stalled     = r_stalled;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_decoder
// Description : Self-checking bench for seg7_scan_decoder: directed sequences,
//               a pattern table and randomized scans against a hold-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 1024;

`ifdef SEG7_DECODE_BIN_EN
    localparam bit c_BIN = 1'b1;
`else
    localparam bit c_BIN = 1'b0;
`endif

    localparam logic [3:0] c_IDLE_AN  = 4'b1111;
    localparam logic [6:0] c_IDLE_SEG = 7'b1111111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_decoder_if bus ();

    seg7_scan_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_fast (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    logic [3:0] an_of  [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] pat_of [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    typedef struct {
        logic [6:0] pat;
        logic [3:0] code;
        logic       bad;
        int         sec;
    } vec_t;
    vec_t tbl [13];

    int n_checks = 0;
    int n_err    = 0;
    int fv_count = 0;
    int fv0;

    // hold-level reference model state
    logic [3:0] m_pend [4];
    logic [3:0] m_mask;
    logic [15:0] m_digits;
    logic [3:0] m_seg_err;
    logic       m_anode_err;
    int         m_frames;
    int         m_min, m_sec;

    always @(posedge clk) begin
        #1;
        if (bus.frame_valid) fv_count++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.Anode_Activate = an;
        bus.LED_out        = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan4(input logic [6:0] p3, input logic [6:0] p2,
                         input logic [6:0] p1, input logic [6:0] p0);
        drive(an_of[3], p3, 4);
        drive(an_of[2], p2, 4);
        drive(an_of[1], p1, 4);
        drive(an_of[0], p0, 4);
        drive(c_IDLE_AN, c_IDLE_SEG, 4);
    endtask

    task automatic clear_errs();
        bus.err_clr = 1'b1;
        drive(c_IDLE_AN, c_IDLE_SEG, 1);
        bus.err_clr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_digits"},  32'(bus.digits), 32'h0);
        chk({tag, "_fv"},      32'(bus.frame_valid), 32'h0);
        chk({tag, "_segerr"},  32'(bus.seg_err), 32'h0);
        chk({tag, "_anerr"},   32'(bus.anode_err), 32'h0);
        chk({tag, "_stalled"}, 32'(bus.stalled), 32'h0);
        chk({tag, "_min"},     32'(bus.minutes), 32'h0);
        chk({tag, "_sec"},     32'(bus.seconds), 32'h0);
    endtask

    function automatic logic [3:0] code_of(input logic [6:0] seg);
        logic [3:0] c = 4'hF;
        if (seg == 7'b1111111) c = 4'hA;
        for (int i = 0; i < 10; i++) if (seg == pat_of[i]) c = 4'(i);
        return c;
    endfunction

    function automatic int bin_of(input logic [3:0] c);
        return (c <= 4'd9) ? int'(c) : 0;
    endfunction

    // A window of len cycles is captured when len >= SETTLE on a single-digit anode
    task automatic model_hold(input logic [3:0] an, input logic [6:0] seg, input int len);
        int idx = -1;
        logic [3:0] c;
        for (int i = 0; i < 4; i++) if (an == an_of[i]) idx = i;
        if ($countones(~an) > 1) m_anode_err = 1'b1;
        if (len >= SETTLE && idx >= 0) begin
            c = code_of(seg);
            m_pend[idx] = c;
            m_mask[idx] = 1'b1;
            if (c == 4'hF) m_seg_err[idx] = 1'b1;
            if (m_mask == 4'hF) begin
                m_frames++;
                m_digits = {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
                if (m_pend[0] != 4'hF && m_pend[1] != 4'hF && m_pend[2] != 4'hF && m_pend[3] != 4'hF) begin
                    m_min = bin_of(m_pend[3]) * 10 + bin_of(m_pend[2]);
                    m_sec = bin_of(m_pend[1]) * 10 + bin_of(m_pend[0]);
                end
                m_mask = 4'h0;
            end
        end
    endtask

    initial begin
        logic [3:0] an, pan;
        logic [6:0] seg, pseg;
        int len, r;

        tbl[0]  = '{pat_of[0], 4'h0, 1'b0, 70};
        tbl[1]  = '{pat_of[1], 4'h1, 1'b0, 71};
        tbl[2]  = '{pat_of[2], 4'h2, 1'b0, 72};
        tbl[3]  = '{pat_of[3], 4'h3, 1'b0, 73};
        tbl[4]  = '{pat_of[4], 4'h4, 1'b0, 74};
        tbl[5]  = '{pat_of[5], 4'h5, 1'b0, 75};
        tbl[6]  = '{pat_of[6], 4'h6, 1'b0, 76};
        tbl[7]  = '{pat_of[7], 4'h7, 1'b0, 77};
        tbl[8]  = '{pat_of[8], 4'h8, 1'b0, 78};
        tbl[9]  = '{pat_of[9], 4'h9, 1'b0, 79};
        tbl[10] = '{7'b1111111, 4'hA, 1'b0, 70};
        tbl[11] = '{7'b1111110, 4'hF, 1'b1, 70};
        tbl[12] = '{7'b0110111, 4'hF, 1'b1, 70};

        bus.Anode_Activate = c_IDLE_AN;
        bus.LED_out        = c_IDLE_SEG;
        bus.err_clr        = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        drive(c_IDLE_AN, c_IDLE_SEG, 2);

        // 12:34 with frame_valid latency on the completing digit
        fv0 = fv_count;
        drive(an_of[3], pat_of[1], 4);
        drive(an_of[2], pat_of[2], 4);
        drive(an_of[1], pat_of[3], 4);
        drive(an_of[0], pat_of[4], SETTLE + 1);
        chk("lat_fv_early", 32'(bus.frame_valid), 32'h0);
        drive(an_of[0], pat_of[4], 1);
        chk("lat_fv_on", 32'(bus.frame_valid), 32'h1);
        drive(an_of[0], pat_of[4], 2);
        drive(c_IDLE_AN, c_IDLE_SEG, 4);
        chk("scan_frames", 32'(fv_count - fv0), 32'd1);
        chk("scan_digits", 32'(bus.digits), 32'h1234);
        chk("scan_min", 32'(bus.minutes), c_BIN ? 32'd12 : 32'd0);
        chk("scan_sec", 32'(bus.seconds), c_BIN ? 32'd34 : 32'd0);
        chk("scan_segerr", 32'(bus.seg_err), 32'h0);
        chk("scan_anerr", 32'(bus.anode_err), 32'h0);

        // single-cycle glitch on digit 2 is not captured
        fv0 = fv_count;
        drive(an_of[3], pat_of[5], 4);
        drive(an_of[2], pat_of[6], 1);
        drive(an_of[1], pat_of[7], 4);
        drive(an_of[0], pat_of[8], 4);
        drive(c_IDLE_AN, c_IDLE_SEG, 4);
        chk("glitch_noframe", 32'(fv_count - fv0), 32'd0);
        drive(an_of[2], pat_of[6], 4);
        drive(c_IDLE_AN, c_IDLE_SEG, 4);
        chk("glitch_frame", 32'(fv_count - fv0), 32'd1);
        chk("glitch_digits", 32'(bus.digits), 32'h5678);

        // bad pattern on digit 0 keeps the binary outputs
        scan4(pat_of[1], pat_of[2], pat_of[3], pat_of[4]);
        scan4(pat_of[1], pat_of[2], pat_of[3], 7'b1111110);
        chk("bad_digits", 32'(bus.digits), 32'h123F);
        chk("bad_segerr", 32'(bus.seg_err), 32'h1);
        chk("bad_min", 32'(bus.minutes), c_BIN ? 32'd12 : 32'd0);
        chk("bad_sec", 32'(bus.seconds), c_BIN ? 32'd34 : 32'd0);
        clear_errs();
        chk("bad_clr", 32'(bus.seg_err), 32'h0);

        // invalid anode, clear, and error-over-clear priority
        fv0 = fv_count;
        drive(4'b0011, pat_of[1], 5);
        chk("inv_anerr", 32'(bus.anode_err), 32'h1);
        drive(c_IDLE_AN, c_IDLE_SEG, 4);
        chk("inv_noframe", 32'(fv_count - fv0), 32'd0);
        chk("inv_digits", 32'(bus.digits), 32'h123F);
        clear_errs();
        chk("inv_clr", 32'(bus.anode_err), 32'h0);
        bus.err_clr = 1'b1;
        drive(4'b0011, pat_of[1], 2);
        bus.err_clr = 1'b0;
        chk("inv_prio", 32'(bus.anode_err), 32'h1);
        drive(c_IDLE_AN, c_IDLE_SEG, 2);
        clear_errs();

        // pattern table on digit 0
        for (int i = 0; i < 13; i++) begin
            fv0 = fv_count;
            scan4(pat_of[5], pat_of[6], pat_of[7], tbl[i].pat);
            chk($sformatf("tbl%0d_frame", i), 32'(fv_count - fv0), 32'd1);
            chk($sformatf("tbl%0d_digits", i), 32'(bus.digits), {16'h0, 12'h567, tbl[i].code});
            chk($sformatf("tbl%0d_segerr", i), 32'(bus.seg_err), {31'h0, tbl[i].bad});
            chk($sformatf("tbl%0d_min", i), 32'(bus.minutes), c_BIN ? 32'd56 : 32'd0);
            chk($sformatf("tbl%0d_sec", i), 32'(bus.seconds), c_BIN ? 32'(tbl[i].sec) : 32'd0);
            clear_errs();
        end

        // stall after TIMEOUT frozen cycles, release two edges after a change
        drive(an_of[0], pat_of[0], TIMEOUT + 1);
        chk("stall_early", 32'(bus.stalled), 32'h0);
        drive(an_of[0], pat_of[0], 1);
        chk("stall_on", 32'(bus.stalled), 32'h1);
        drive(an_of[1], pat_of[0], 1);
        chk("stall_hold", 32'(bus.stalled), 32'h1);
        drive(an_of[1], pat_of[0], 1);
        chk("stall_off", 32'(bus.stalled), 32'h0);

        // reset mid-frame discards pending captures
        drive(an_of[3], pat_of[9], 4);
        drive(an_of[2], pat_of[8], 4);
        rst_n = 1'b0;
        drive(c_IDLE_AN, c_IDLE_SEG, 2);
        chk_all_zero("midrst");
        rst_n = 1'b1;
        fv0 = fv_count;
        drive(an_of[1], pat_of[7], 4);
        drive(an_of[0], pat_of[6], 4);
        drive(c_IDLE_AN, c_IDLE_SEG, 4);
        chk("midrst_noframe", 32'(fv_count - fv0), 32'd0);
        drive(an_of[3], pat_of[9], 4);
        drive(an_of[2], pat_of[8], 4);
        drive(c_IDLE_AN, c_IDLE_SEG, 4);
        chk("midrst_frame", 32'(fv_count - fv0), 32'd1);
        chk("midrst_digits", 32'(bus.digits), 32'h9876);

        // randomized scans against the hold-level model
        rst_n = 1'b0;
        drive(c_IDLE_AN, c_IDLE_SEG, 2);
        rst_n = 1'b1;
        drive(c_IDLE_AN, c_IDLE_SEG, 2);
        for (int i = 0; i < 4; i++) m_pend[i] = 4'h0;
        m_mask = 4'h0; m_digits = 16'h0; m_seg_err = 4'h0; m_anode_err = 1'b0;
        m_frames = 0; m_min = 0; m_sec = 0;
        fv0 = fv_count;
        for (int b = 0; b < 15; b++) begin
            pan  = c_IDLE_AN;
            pseg = c_IDLE_SEG;
            for (int h = 0; h < 12; h++) begin
                do begin
                    r = $urandom_range(0, 19);
                    if (r < 14)      an = an_of[$urandom_range(0, 3)];
                    else if (r < 17) an = c_IDLE_AN;
                    else             an = 4'($urandom_range(0, 15));
                    r = $urandom_range(0, 9);
                    if (r < 7)       seg = pat_of[$urandom_range(0, 9)];
                    else if (r < 8)  seg = c_IDLE_SEG;
                    else             seg = 7'($urandom);
                end while ({an, seg} == {pan, pseg});
                len = $urandom_range(1, 5);
                model_hold(an, seg, len);
                drive(an, seg, len);
                pan  = an;
                pseg = seg;
            end
            drive(c_IDLE_AN, c_IDLE_SEG, SETTLE + 4);
            chk($sformatf("rnd%0d_frames", b), 32'(fv_count - fv0), 32'(m_frames));
            chk($sformatf("rnd%0d_digits", b), 32'(bus.digits), 32'(m_digits));
            chk($sformatf("rnd%0d_segerr", b), 32'(bus.seg_err), 32'(m_seg_err));
            chk($sformatf("rnd%0d_anerr", b), 32'(bus.anode_err), 32'(m_anode_err));
            chk($sformatf("rnd%0d_min", b), 32'(bus.minutes), c_BIN ? 32'(m_min) : 32'd0);
            chk($sformatf("rnd%0d_sec", b), 32'(bus.seconds), c_BIN ? 32'(m_sec) : 32'd0);
            chk($sformatf("rnd%0d_stalled", b), 32'(bus.stalled), 32'h0);
            clear_errs();
            m_seg_err   = 4'h0;
            m_anode_err = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
